// File: rtl/rapid_pkg.sv
// Shared RAPID cache-interface types plus the helpers used by the data-memory responder.
// Lane strobes and alignment rules live here so the core and memory agree on one definition.
package rapid_pkg;

    localparam int WORD_WIDTH = 4;

    typedef enum logic {
        CACHE_READ  = 1'b0,
        CACHE_WRITE = 1'b1
    } cache_rw;

    typedef enum logic [1:0] {
        CACHE_NOP = 2'd0,
        BYTE      = 2'd1,
        HALF_WORD = 2'd2,
        WORD      = 2'd3
    } cache_operation;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    function automatic logic [3:0] lane_strobe(input cache_operation op, input logic [1:0] a);
        logic [3:0] strb;
        case (op)
            BYTE:      strb = 4'b0001 << a;
            HALF_WORD: strb = 4'b0011 << a;
            WORD:      strb = 4'b1111;
            default:   strb = 4'b0000;
        endcase
        return strb;
    endfunction

    function automatic logic is_misaligned(input cache_operation op, input logic [1:0] a);
        logic mis;
        case (op)
            HALF_WORD: mis = a[0];
            WORD:      mis = |a;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/rapid_load_align.sv
// Picks the addressed byte/half/word out of a memory word and sign- or zero-extends it.
// Purely combinational; the responder registers the result.
module rapid_load_align
    import rapid_pkg::*;
#(
    parameter int DATA_WIDTH = WORD_WIDTH * 8
) (
    input  cache_operation        op,
    input  logic [1:0]            lane,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output gets a value on every path through the block, so no latch is inferred.
    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];
        data     = '0;
        case (op)
            BYTE:      data = {{(DATA_WIDTH-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
            HALF_WORD: data = {{(DATA_WIDTH-16){half_sel[15] & ~is_unsigned}}, half_sel};
            WORD:      data = word;
            default:   data = '0;
        endcase
    end

endmodule

// File: rtl/rapid_dmem_responder.sv
// Data-cache request responder: accepts one request, runs it on a word-wide req/ack memory
// bus with a timeout, and returns a one-cycle response with extended read data or an error.
module rapid_dmem_responder
    import rapid_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = WORD_WIDTH * 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  cache_rw               req_rw,
    input  cache_operation        req_op,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    dmem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    cache_operation        op_q, op_d;
    logic                  uns_q, uns_d;
    logic [1:0]            lane_q, lane_d;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic                  req_mis;

    rapid_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .op          (op_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .word        (mem_rdata),
        .data        (load_data)
    );

    always_comb begin
        req_mis = is_misaligned(req_op, req_addr[1:0]);
        case (req_op)
            BYTE:      wdata_rep = {(DATA_WIDTH/8){req_wdata[7:0]}};
            HALF_WORD: wdata_rep = {(DATA_WIDTH/16){req_wdata[15:0]}};
            default:   wdata_rep = req_wdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        // Response fields default low so they are only visible in the single RESP cycle.
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    uns_d  = req_unsigned;
                    lane_d = req_addr[1:0];
                    cnt_d  = '0;
                    if (req_op == CACHE_NOP || req_mis) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = req_mis;
                    end else begin
                        state_d     = MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (req_rw == CACHE_WRITE);
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wstrb_d = lane_strobe(req_op, req_addr[1:0]);
                        mem_wdata_d = wdata_rep;
                    end
                end
            end
            MEM: begin
                if (mem_ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ~mem_ack;
                    resp_rdata_d = (mem_ack && !mem_we_q) ? load_data : '0;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wstrb_d  = '0;
                    mem_wdata_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= CACHE_NOP;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_rapid_dmem_responder.sv
// Bench for rapid_dmem_responder: directed vector table, randomized requests against a
// lane-arithmetic reference model, plus timeout, late-ack and mid-access reset sequences.
module tb_rapid_dmem_responder;
    import rapid_pkg::*;

    localparam int TIMEOUT = 255;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    cache_rw        req_rw;
    cache_operation req_op;
    logic           req_unsigned;
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_err;
    logic           mem_req;
    logic           mem_we;
    logic [31:0]    mem_addr;
    logic [3:0]     mem_wstrb;
    logic [31:0]    mem_wdata;
    logic           mem_ack;
    logic [31:0]    mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rapid_dmem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_op       (req_op),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        string          name;
        cache_rw        rw;
        cache_operation op;
        logic           uns;
        logic [31:0]    addr;
        logic [31:0]    wdata;
        logic [31:0]    rdata;
        int             ack_delay;   // mem_req cycles before ack; -1 = never ack
        logic           exp_mem;
        logic           exp_we;
        logic [31:0]    exp_addr;
        logic [3:0]     exp_wstrb;
        logic [31:0]    exp_wdata;
        logic [31:0]    exp_rdata;
        logic           exp_err;
        int             exp_resp;    // cycles after accept edge until resp_valid
    } vec_t;

    typedef struct {
        logic        ready_at_accept;
        logic        got_mem;
        int          mem_cycles;
        int          mem_first;
        logic        unstable;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        got_resp;
        int          resp_cyc;
        logic [31:0] rdata;
        logic        err;
        logic        resp_after;
        logic        ready_after;
    } obs_t;

    vec_t tbl[$];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input cache_rw rw, input cache_operation op,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int dly, input logic em,
                                input logic ew, input logic [31:0] ea, input logic [3:0] es,
                                input logic [31:0] ewd, input logic [31:0] erd, input logic ee,
                                input int er);
        vec_t v;
        v.name = name; v.rw = rw; v.op = op; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.ack_delay = dly; v.exp_mem = em; v.exp_we = ew; v.exp_addr = ea;
        v.exp_wstrb = es; v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_err = ee; v.exp_resp = er;
        return v;
    endfunction

    // Reference model: derives the expected bus and response purely from access size and byte offset.
    function automatic vec_t model(input string name, input cache_rw rw, input cache_operation op,
                                   input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rdata, input int dly);
        vec_t   v;
        int     size;
        int     off;
        longint val;
        v = mk(name, rw, op, uns, addr, wdata, rdata, dly, 0, 0, 0, 0, 0, 0, 0, 1);
        size = (op == BYTE) ? 1 : (op == HALF_WORD) ? 2 : (op == WORD) ? 4 : 0;
        off  = int'(addr % 4);
        if (size == 0) return v;
        if (off % size != 0) begin
            v.exp_err = 1;
            return v;
        end
        v.exp_mem  = 1;
        v.exp_we   = (rw == CACHE_WRITE);
        v.exp_addr = addr - 32'(off);
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) v.exp_wstrb[i] = 1'b1;
            v.exp_wdata = v.exp_wdata | (((wdata >> (8 * (i % size))) & 32'hFF) << (8 * i));
        end
        if (rw == CACHE_READ) begin
            val = longint'((rdata >> (8 * off)) & 32'hFFFF_FFFF);
            val = val % (longint'(1) << (8 * size));
            if (!uns && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
            v.exp_rdata = 32'(val);
        end
        v.exp_resp = dly + 2;
        return v;
    endfunction

    task automatic run_txn(input vec_t t, output obs_t o);
        o = '{default: '0};
        @(negedge clk);
        req_valid    = 1'b1;
        req_rw       = t.rw;
        req_op       = t.op;
        req_unsigned = t.uns;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
        o.ready_at_accept = req_ready;
        @(posedge clk);
        #1;
        // Scramble request fields after acceptance; the DUT must use its registered copy.
        req_valid    = 1'b0;
        req_op       = cache_operation'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        for (int cyc = 1; cyc <= TIMEOUT + 20 && !o.got_resp; cyc++) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (!o.got_mem) begin
                    o.mem_first = cyc;
                    o.we = mem_we; o.addr = mem_addr; o.wstrb = mem_wstrb; o.wdata = mem_wdata;
                end else if (mem_we !== o.we || mem_addr !== o.addr || mem_wstrb !== o.wstrb ||
                             mem_wdata !== o.wdata) begin
                    o.unstable = 1'b1;
                end
                o.got_mem = 1'b1;
                o.mem_cycles++;
                if (t.ack_delay >= 0 && o.mem_cycles == t.ack_delay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = t.rdata;
                end
            end
            if (resp_valid) begin
                o.got_resp = 1'b1;
                o.resp_cyc = cyc;
                o.rdata    = resp_rdata;
                o.err      = resp_err;
            end
        end
        @(negedge clk);
        mem_ack       = 1'b0;
        o.resp_after  = resp_valid;
        o.ready_after = req_ready;
    endtask

    task automatic score(input vec_t v, input obs_t o);
        int exp_mcyc;
        exp_mcyc = !v.exp_mem ? 0 : (v.ack_delay < 0) ? TIMEOUT : v.ack_delay + 1;
        check({v.name, ".ready_at_accept"}, 32'(o.ready_at_accept), 1);
        check({v.name, ".mem_req_seen"}, 32'(o.got_mem), 32'(v.exp_mem));
        check({v.name, ".mem_cycles"}, 32'(o.mem_cycles), 32'(exp_mcyc));
        check({v.name, ".resp_cycle"}, 32'(o.resp_cyc), 32'(v.exp_resp));
        check({v.name, ".resp_rdata"}, o.rdata, v.exp_rdata);
        check({v.name, ".resp_err"}, 32'(o.err), 32'(v.exp_err));
        check({v.name, ".resp_one_cycle"}, 32'(o.resp_after), 0);
        check({v.name, ".ready_after"}, 32'(o.ready_after), 1);
        if (v.exp_mem) begin
            check({v.name, ".mem_first"}, 32'(o.mem_first), 1);
            check({v.name, ".mem_we"}, 32'(o.we), 32'(v.exp_we));
            check({v.name, ".mem_addr"}, o.addr, v.exp_addr);
            check({v.name, ".mem_wstrb"}, 32'(o.wstrb), 32'(v.exp_wstrb));
            check({v.name, ".mem_wdata"}, o.wdata, v.exp_wdata);
            check({v.name, ".mem_stable"}, 32'(o.unstable), 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".req_ready"}, 32'(req_ready), 1);
        check({tag, ".resp_valid"}, 32'(resp_valid), 0);
        check({tag, ".resp_rdata"}, resp_rdata, 0);
        check({tag, ".resp_err"}, 32'(resp_err), 0);
        check({tag, ".mem_req"}, 32'(mem_req), 0);
        check({tag, ".mem_we"}, 32'(mem_we), 0);
        check({tag, ".mem_addr"}, mem_addr, 0);
        check({tag, ".mem_wstrb"}, 32'(mem_wstrb), 0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        vec_t v;
        logic saw_resp;

        tbl.push_back(mk("word_wr", CACHE_WRITE, WORD, 0, 32'h100, 32'hDEADBEEF, 0, 0,
                         1, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 2));
        tbl.push_back(mk("byte_rd_s", CACHE_READ, BYTE, 0, 32'h103, 0, 32'h80FF_0000, 0,
                         1, 0, 32'h100, 4'b1000, 0, 32'hFFFF_FF80, 0, 2));
        tbl.push_back(mk("byte_rd_u", CACHE_READ, BYTE, 1, 32'h103, 0, 32'h80FF_0000, 0,
                         1, 0, 32'h100, 4'b1000, 0, 32'h0000_0080, 0, 2));
        tbl.push_back(mk("half_wr", CACHE_WRITE, HALF_WORD, 0, 32'h22, 32'h1234, 0, 0,
                         1, 1, 32'h20, 4'b1100, 32'h1234_1234, 0, 0, 2));
        tbl.push_back(mk("half_mis", CACHE_READ, HALF_WORD, 0, 32'h21, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk("word_mis", CACHE_WRITE, WORD, 0, 32'h202, 32'h1111_2222, 0, 0,
                         0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk("half_rd_hi", CACHE_READ, HALF_WORD, 0, 32'h42, 0, 32'h8001_7FFF, 3,
                         1, 0, 32'h40, 4'b1100, 0, 32'hFFFF_8001, 0, 5));
        tbl.push_back(mk("byte_wr", CACHE_WRITE, BYTE, 0, 32'h31, 32'hFFFF_FFA5, 0, 1,
                         1, 1, 32'h30, 4'b0010, 32'hA5A5_A5A5, 0, 0, 3));
        tbl.push_back(mk("word_rd", CACHE_READ, WORD, 0, 32'h40, 0, 32'h1234_5678, 1,
                         1, 0, 32'h40, 4'b1111, 0, 32'h1234_5678, 0, 3));
        tbl.push_back(mk("half_rd_u", CACHE_READ, HALF_WORD, 1, 32'h10, 0, 32'h0000_F00D, 0,
                         1, 0, 32'h10, 4'b0011, 0, 32'h0000_F00D, 0, 2));
        tbl.push_back(mk("half_rd_s", CACHE_READ, HALF_WORD, 0, 32'h10, 0, 32'h0000_F00D, 2,
                         1, 0, 32'h10, 4'b0011, 0, 32'hFFFF_F00D, 0, 4));
        tbl.push_back(mk("word_timeout", CACHE_READ, WORD, 0, 32'h300, 32'h5555_AAAA, 0, -1,
                         1, 0, 32'h300, 4'b1111, 32'h5555_AAAA, 0, 1, TIMEOUT + 1));
        tbl.push_back(mk("nop", CACHE_WRITE, CACHE_NOP, 0, 32'h123, 32'hFFFF_FFFF, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 1));

        rst = 1'b1; req_valid = 1'b0; req_rw = CACHE_READ; req_op = CACHE_NOP;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_txn(tbl[i], o);
            score(tbl[i], o);
        end

        // A stray ack while idle must not start or complete anything.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_idle_outputs("late_ack.a");
        @(negedge clk);
        check_idle_outputs("late_ack.b");

        // Reset while the memory request is outstanding abandons it without a response.
        req_valid = 1'b1; req_rw = CACHE_WRITE; req_op = WORD; req_addr = 32'h80;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid.mem_req_before", 32'(mem_req), 1);
        check("rst_mid.ready_before", 32'(req_ready), 0);
        rst = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        saw_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_resp = saw_resp | resp_valid | mem_req;
        end
        check("rst_mid.no_activity_after", 32'(saw_resp), 0);
        run_txn(tbl[0], o);
        score(tbl[0], o);

        for (int k = 0; k < 40; k++) begin
            v = model($sformatf("rand%0d", k), cache_rw'($urandom_range(0, 1)),
                      cache_operation'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom & 32'h0000_FFFF, $urandom, $urandom, int'($urandom_range(0, 3)));
            run_txn(v, o);
            score(v, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rapid_dmem_responder.md
Name: rapid_dmem_responder

Overview:
Target (responder) side of the RAPID core's data-cache request interface. It accepts one request at a time, described by cache_rw, cache_operation, address and write data. It performs the access on a word-wide backing-memory bus using a req/ack handshake. It returns lane-extracted, sign- or zero-extended read data, or an error, to the core-side initiator.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, bus width; equals WORD_WIDTH*8 from rapid_pkg.
TIMEOUT, 255, maximum cycles mem_req waits for mem_ack before the access is aborted with an error.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_rw  in  cache_rw  CACHE_READ / CACHE_WRITE
req_op  in  cache_operation  CACHE_NOP / BYTE / HALF_WORD / WORD
req_unsigned  in  1  zero-extend read data (1) or sign-extend (0)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_WIDTH  extended read data; 0 for writes, NOPs and errors
resp_err  out  1  misaligned access or timeout; qualified by resp_valid
mem_req  out  1  backing-memory request, held until mem_ack or timeout
mem_we  out  1  write enable
mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits forced to 0)
mem_wstrb  out  4  byte-lane strobes
mem_wdata  out  DATA_WIDTH  lane-replicated write data
mem_ack  in  1  memory completion; read data valid in the same cycle
mem_rdata  in  DATA_WIDTH  memory read word

Behaviour:
- Reset: state IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_err=0. mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0. Timeout counter=0.
- req_ready is 1 exactly when state==IDLE. A request is accepted on req_valid && req_ready, and all request fields are registered at that edge.
- FSM states: IDLE, MEM, RESP.
- IDLE -> RESP on an accepted NOP: no memory access, err=0, rdata=0.
- IDLE -> RESP on an accepted misaligned request: no memory access, err=1.
  - HALF_WORD is misaligned when addr[0]=1.
  - WORD is misaligned when addr[1:0]!=0.
  - BYTE is never misaligned.
- IDLE -> MEM on any other accepted request.
  - mem_req=1, mem_we=(rw==CACHE_WRITE), mem_addr={addr[hi:2],2'b00}.
  - mem_wstrb: BYTE = 4'b0001<<addr[1:0]; HALF_WORD = 4'b0011<<addr[1:0]; WORD = 4'b1111. mem_wstrb is also driven for reads.
  - mem_wdata: byte replicated ×4, half replicated ×2, or the full word.
- MEM -> RESP on mem_ack.
  - mem_req drops in the same edge.
  - For reads, the selected lane of mem_rdata is extended per req_unsigned and captured.
- MEM -> RESP on timeout: the counter reaches TIMEOUT with no ack; mem_req drops and err=1.
- mem_ack outside MEM is ignored.
- RESP -> IDLE unconditionally. resp_valid=1 for exactly one cycle, with no backpressure.
- Latency, zero-wait memory (ack in the first mem_req cycle): accept at edge N, mem_req high in cycle N+1, resp_valid in cycle N+2, next accept at edge N+3.
- Misaligned and NOP requests: resp_valid in cycle N+1.
- Mid-operation rst: abort immediately and return to reset values. Any in-flight memory transaction is abandoned; the memory must tolerate a dropped mem_req.
- mem_* outputs hold stable while mem_req=1.

Decomposition:
- Add to rapid_pkg:
  - typedef enum dmem_state_e {IDLE, MEM, RESP}.
  - Function lane_strobe(cache_operation, addr[1:0]) returning 4 bits.
  - Function is_misaligned(cache_operation, addr[1:0]).
- One natural sub-module, rapid_load_align: combinational lane select plus sign/zero extension from (op, addr[1:0], unsigned, word) to DATA_WIDTH.

Test Plan:
- Reset, then WORD write addr=0x100 data=0xDEADBEEF with ack on the first cycle -> mem_addr=0x100, mem_wstrb=1111, mem_wdata=0xDEADBEEF; resp_valid two cycles after accept, err=0, rdata=0.
- BYTE read addr=0x103, signed, mem_rdata=0x80FF_0000 -> mem_wstrb=1000; resp_rdata=0xFFFFFF80. Repeat unsigned -> 0x00000080.
- HALF_WORD write addr=0x22 data=0x1234 -> mem_addr=0x20, wstrb=1100, wdata=0x12341234. HALF_WORD read addr=0x21 -> mem_req never asserted; resp_valid one cycle after accept, err=1.
- WORD read with mem_ack withheld -> mem_req held for TIMEOUT cycles, then deasserted; resp_err=1, rdata=0, req_ready returns 1 the following cycle.
- CACHE_NOP request -> no mem_req; resp_valid next cycle, err=0. A late mem_ack pulse in IDLE has no effect.
- rst asserted while in MEM with mem_req=1 -> next cycle all outputs at reset values; no resp_valid.
